// File: rtl/sync_fifo_prog.sv
// Parametrised single-clock FIFO with selectable registered-read or first-word-fall-through
// output, programmable almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module sync_fifo_prog #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clr_err,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_CNT    = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_CNT    = (ADDR_W+1)'(AE_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [DATA_W-1:0] std_data;
  logic              std_valid;
  logic              rd_ok;
  logic              wr_ok;

  // Accept decisions and status flags, all from pre-edge state
  always_comb begin
    full         = (count == DEPTH_CNT);
    empty        = (count == {(ADDR_W+1){1'b0}});
    almost_full  = (count >= AF_CNT);
    almost_empty = (count <= AE_CNT);
    rd_ok        = pop && !empty;
    // A full FIFO still takes a push when the same cycle frees a slot
    wr_ok        = push && (!full || pop);
  end

  // Storage array; deliberately not cleared by reset
  always_ff @(posedge clk) begin
    if (wr_ok && !rst) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= {ADDR_W{1'b0}};
      rd_ptr <= {ADDR_W{1'b0}};
      count  <= {(ADDR_W+1){1'b0}};
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      if (wr_ok && !rd_ok) begin
        count <= count + (ADDR_W+1)'(1);
      end else if (rd_ok && !wr_ok) begin
        count <= count - (ADDR_W+1)'(1);
      end
    end
  end

  // Registered read path used in standard mode
  always_ff @(posedge clk) begin
    if (rst) begin
      std_data  <= {DATA_W{1'b0}};
      std_valid <= 1'b0;
    end else begin
      std_valid <= rd_ok;
      if (rd_ok) begin
        std_data <= mem[rd_ptr];
      end
    end
  end

  // Sticky error flags; a fresh error wins over a concurrent clear
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push && full && !pop) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (pop && empty) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

  // Output mode selection
  always_comb begin
    data_out   = std_data;
    data_valid = std_valid;
    if (FWFT != 0) begin
      data_valid = !empty;
      if (empty) begin
        data_out = {DATA_W{1'b0}};
      end else begin
        data_out = mem[rd_ptr];
      end
    end else begin
      data_out   = std_data;
      data_valid = std_valid;
    end
  end

endmodule
